// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks in-flight load and multi-cycle destinations and stalls ID
// when forwarding cannot yet supply an operand. Optional counters: HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int unsigned LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_flush,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_is_long,
    input  logic        long_done,
    input  logic [4:0]  long_rd,
    output logic        stall_id,
    output logic        long_busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] load_stalls
`endif
);

    localparam logic [1:0] LdInit = 2'(LOAD_BUBBLES);

    // Entry 0 exists only so indices need no offset; it is held at zero.
    logic [1:0]  ld_cnt_q [32];
    logic [1:0]  ld_cnt_d [32];
    logic [31:0] long_pend_q, long_pend_d;
    logic        long_busy_q, long_busy_d;

    logic id_live;
    logic issue;
    logic rs1_ld, rs2_ld;
    logic rs1_long, rs2_long;
    logic waw_hz;
    logic struct_hz;
    logic rd_tracked;

    // Hazard detection
    always_comb begin
        id_live    = id_valid && !id_flush;
        rs1_ld     = id_uses_rs1 && (id_rs1 != 5'd0) && (ld_cnt_q[id_rs1] != 2'd0);
        rs2_ld     = id_uses_rs2 && (id_rs2 != 5'd0) && (ld_cnt_q[id_rs2] != 2'd0);
        rs1_long   = id_uses_rs1 && (id_rs1 != 5'd0) && long_pend_q[id_rs1];
        rs2_long   = id_uses_rs2 && (id_rs2 != 5'd0) && long_pend_q[id_rs2];
        waw_hz     = id_reg_write && (id_rd != 5'd0) && long_pend_q[id_rd];
        struct_hz  = id_is_long && long_busy_q;
        stall_id   = id_live && (rs1_ld || rs2_ld || rs1_long || rs2_long || waw_hz || struct_hz);
        issue      = id_live && !stall_id;
        rd_tracked = id_reg_write && (id_rd != 5'd0);
        long_busy  = long_busy_q;
    end

    // Next state: age load counters, retire multi-cycle results, then let issue override.
    always_comb begin
        ld_cnt_d[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            ld_cnt_d[i] = (ld_cnt_q[i] != 2'd0) ? ld_cnt_q[i] - 2'd1 : 2'd0;
        end
        long_pend_d = long_pend_q;
        long_busy_d = long_busy_q;

        if (long_done) begin
            long_busy_d = 1'b0;
            if (long_rd != 5'd0) begin
                long_pend_d[long_rd] = 1'b0;
            end
        end

        if (issue) begin
            if (rd_tracked) begin
                if (id_is_load) begin
                    ld_cnt_d[id_rd] = LdInit;
                end else if (id_is_long) begin
                    long_pend_d[id_rd] = 1'b1;
                end else begin
                    ld_cnt_d[id_rd] = 2'd0;
                end
            end
            if (id_is_long) begin
                long_busy_d = 1'b1;
            end
        end

        long_pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ld_cnt_q[i] <= 2'd0;
            end
            long_pend_q <= '0;
            long_busy_q <= 1'b0;
        end else begin
            ld_cnt_q    <= ld_cnt_d;
            long_pend_q <= long_pend_d;
            long_busy_q <= long_busy_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] load_stalls_q, load_stalls_d;
    logic        load_only;

    // A load stall counts only when no multi-cycle or structural cause is also present.
    always_comb begin
        load_only      = (rs1_ld || rs2_ld) && !(rs1_long || rs2_long || waw_hz || struct_hz);
        stall_cycles_d = stall_cycles_q;
        load_stalls_d  = load_stalls_q;
        if (stall_id && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (stall_id && load_only && (load_stalls_q != 32'hFFFF_FFFF)) begin
            load_stalls_d = load_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            load_stalls_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_stalls_q  <= load_stalls_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign load_stalls  = load_stalls_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (LOAD_BUBBLES 1 and 2) share stimulus and
// each cycle's expected stall/busy values go through a scoreboard queue.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_flush;
    logic [4:0] id_rs1, id_rs2, id_rd, long_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load, id_is_long;
    logic       long_done;
    logic       stall1, busy1, stall2, busy2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        logic  s1;
        logic  s2;
        logic  busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.LOAD_BUBBLES(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_is_long(id_is_long), .long_done(long_done), .long_rd(long_rd),
        .stall_id(stall1), .long_busy(busy1)
    );

    hazard_scoreboard #(.LOAD_BUBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_is_long(id_is_long), .long_done(long_done), .long_rd(long_rd),
        .stall_id(stall2), .long_busy(busy2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present an instruction in ID (valid=1, no flush).
    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic ld, input logic lg);
        id_valid = 1'b1; id_flush = 1'b0;
        id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = we; id_is_load = ld; id_is_long = lg;
    endtask

    task automatic idle();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
    endtask

    // One cycle: record expectations, compare mid-cycle, advance past the next rising edge.
    task automatic cyc(input string tag, input logic s1, input logic s2, input logic b);
        exp_t e;
        exp_t got;
        e.tag = tag; e.s1 = s1; e.s2 = s2; e.busy = b;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        chk({got.tag, ".stall_lb1"}, stall1, got.s1);
        chk({got.tag, ".stall_lb2"}, stall2, got.s2);
        chk({got.tag, ".busy_lb1"}, busy1, got.busy);
        chk({got.tag, ".busy_lb2"}, busy2, got.busy);
        @(posedge clk);
        #1;
        long_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; long_done = 1'b0; long_rd = 5'd0;
        idle();
        @(posedge clk); #1;
        // Instruction with a real source in ID while reset holds: nothing tracked yet.
        instr(5'd5, 1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        cyc("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle();
        cyc("post_reset", 1'b0, 1'b0, 1'b0);

        // Load-use: lw x5; add x6,x5,x1
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc("lw_x5", 1'b0, 1'b0, 1'b0);
        instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        cyc("lu_c0", 1'b1, 1'b1, 1'b0);
        cyc("lu_c1", 1'b0, 1'b1, 1'b0);
        cyc("lu_c2", 1'b0, 1'b0, 1'b0);
        idle();
        cyc("lu_idle", 1'b0, 1'b0, 1'b0);

        // ALU chain: add x5; sub x7,x5,x5
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("alu_add", 1'b0, 1'b0, 1'b0);
        instr(5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        cyc("alu_sub", 1'b0, 1'b0, 1'b0);

        // x0 never tracked
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("lw_x0", 1'b0, 1'b0, 1'b0);
        instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        cyc("use_x0", 1'b0, 1'b0, 1'b0);

        // Unused rs2 matching a loaded register
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        cyc("lw_x8", 1'b0, 1'b0, 1'b0);
        instr(5'd2, 1'b1, 5'd8, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        cyc("rs2_unused", 1'b0, 1'b0, 1'b0);
        id_uses_rs2 = 1'b1;
        cyc("rs2_used", 1'b0, 1'b1, 1'b0);
        idle();
        cyc("rs2_idle", 1'b0, 1'b0, 1'b0);

        // Flush: RAW-dependent long op squashed, no stall and no state change
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        cyc("lw_x11", 1'b0, 1'b0, 1'b0);
        instr(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1);
        id_flush = 1'b1;
        cyc("flush", 1'b0, 1'b0, 1'b0);
        idle();
        cyc("flush_nostate", 1'b0, 1'b0, 1'b0);
        instr(5'd12, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        cyc("flush_rd_free", 1'b0, 1'b0, 1'b0);

        // Multi-cycle: div x9; add x1,x9,x2 waits until after long_done
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        cyc("div_x9", 1'b0, 1'b0, 1'b0);
        instr(5'd9, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            cyc("div_wait", 1'b1, 1'b1, 1'b1);
        end
        long_done = 1'b1; long_rd = 5'd9;
        cyc("div_done", 1'b1, 1'b1, 1'b1);
        cyc("div_dep_issue", 1'b0, 1'b0, 1'b0);

        // Structural and WAW while mul x3 pending
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        cyc("mul_x3", 1'b0, 1'b0, 1'b0);
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
        cyc("struct_mul", 1'b1, 1'b1, 1'b1);
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc("waw_x3", 1'b1, 1'b1, 1'b1);
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        cyc("addi_x4", 1'b0, 1'b0, 1'b1);

        // long_done alongside a long op in ID: still stalled this cycle
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1);
        long_done = 1'b1; long_rd = 5'd3;
        cyc("done_vs_long", 1'b1, 1'b1, 1'b1);
        cyc("mul_x14", 1'b0, 1'b0, 1'b0);
        idle();
        cyc("x14_busy", 1'b0, 1'b0, 1'b1);

        // long_done naming a non-pending register clears only long_busy
        long_done = 1'b1; long_rd = 5'd20;
        cyc("spurious_done", 1'b0, 1'b0, 1'b1);
        instr(5'd14, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        cyc("x14_still_pend", 1'b1, 1'b1, 1'b0);
        long_done = 1'b1; long_rd = 5'd14;
        cyc("x14_done", 1'b1, 1'b1, 1'b0);
        cyc("x14_issue", 1'b0, 1'b0, 1'b0);

        // Long op without register write still occupies the unit
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("long_nowr", 1'b0, 1'b0, 1'b0);
        idle();
        cyc("long_nowr_busy", 1'b0, 1'b0, 1'b1);
        long_done = 1'b1; long_rd = 5'd0;
        cyc("long_nowr_done", 1'b0, 1'b0, 1'b1);
        cyc("long_nowr_free", 1'b0, 1'b0, 1'b0);

        // Reset mid-operation
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        cyc("rm_div_x9", 1'b0, 1'b0, 1'b0);
        instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc("rm_lw_x5", 1'b0, 1'b0, 1'b1);
        idle();
        rst = 1'b1;
        cyc("rm_reset", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        instr(5'd9, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        cyc("rm_consumer", 1'b0, 1'b0, 1'b0);
        idle();
        cyc("rm_idle", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
